smpl_lane_sched: RTL and testbench

Sample-lane scheduler sitting between the sample iterator and the parallel sample-test pipeline. It packs the serial per-triangle sample stream into groups of up to LANES samples and issues each group to the test lanes, honouring the downstream halt. It tracks every issued group through the fixed-latency pipeline, accumulates returned hits per triangle, and reports one done record per triangle.

---
 rtl/smpl_sched_pkg.sv | 22 ++
 rtl/smpl_tag_shift.sv | 42 ++++
 rtl/smpl_lane_sched.sv | 165 ++++++++++++++++
 tb/tb_smpl_lane_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smpl_sched_pkg.sv
// smpl_sched_pkg
// Shared definitions for the sample-lane scheduler: default widths, the
// scheduler state encoding and the per-group tracking record that rides
// alongside the sample-test pipeline.
package smpl_sched_pkg;

  localparam int SCHED_LANES = 3;
  localparam int SCHED_TAGW  = 4;
  localparam int SCHED_CNTW  = 16;

  typedef logic [0:0] sched_state_t;
  localparam sched_state_t FILL  = 1'b0;
  localparam sched_state_t ISSUE = 1'b1;

  // Tracking record for one issued group (mask=0 marks an empty slot).
  typedef struct packed {
    logic [SCHED_LANES-1:0] mask;
    logic [SCHED_TAGW-1:0]  tag;
    logic                   last;
  } grp_tag_t;

endpackage

// File: rtl/smpl_tag_shift.sv
// smpl_tag_shift
// DEPTH-stage shift register of group tracking records. It advances only
// when en is high, so it stays aligned with the halt-frozen test pipeline.
// Ports:
//   clk  clock
//   rst  synchronous active-low clear of every stage
//   en   advance enable
//   d    record entering stage 0
//   q    record leaving the last stage
module smpl_tag_shift
  import smpl_sched_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  grp_tag_t d,
  output grp_tag_t q
);

  grp_tag_t stage_reg [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!rst)    stage_reg[gi] <= '0;
          else if (en) stage_reg[gi] <= d;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (!rst)    stage_reg[gi] <= '0;
          else if (en) stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/smpl_lane_sched.sv
// smpl_lane_sched
// Packs the serial per-triangle sample stream into groups of up to LANES
// samples, issues each group to the parallel test lanes (respecting halt),
// shadows every issued group through the fixed-latency test pipeline and
// sums the returned hits per triangle, emitting one done record per triangle.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   in_valid/in_ready            sample handshake
//   in_sample, in_tag, in_last   sample x/y, triangle tag, end of triangle
//   halt                         downstream stall, freezes the test pipeline
//   issue_valid, issue_sample    per-lane group output
//   ret_hit                      per-lane hit, PIPE_DEPTH un-halted cycles later
//   done_valid/tag/hits          one-cycle triangle completion record
//   err                          sticky tag-change-within-group error
module smpl_lane_sched
  import smpl_sched_pkg::*;
#(
  parameter int SIGFIG     = 24,
  parameter int LANES      = SCHED_LANES,
  parameter int PIPE_DEPTH = 3,
  parameter int TAGW       = SCHED_TAGW,
  parameter int CNTW       = SCHED_CNTW
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [1:0][SIGFIG-1:0]              in_sample,
  input  logic [TAGW-1:0]                     in_tag,
  input  logic                                in_last,
  input  logic                                halt,
  output logic [LANES-1:0]                    issue_valid,
  output logic [LANES-1:0][1:0][SIGFIG-1:0]   issue_sample,
  input  logic [LANES-1:0]                    ret_hit,
  output logic                                done_valid,
  output logic [TAGW-1:0]                     done_tag,
  output logic [CNTW-1:0]                     done_hits,
  output logic                                err
);

  localparam int FILLW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int POPW  = $clog2(LANES + 1);
  localparam int SUMW  = CNTW + 1;

  sched_state_t            state_reg;
  logic [FILLW-1:0]        fill_reg;
  logic [LANES-1:0]        mask_reg;
  logic [TAGW-1:0]         tag_reg;
  logic                    last_reg;
  logic                    err_reg;
  logic [1:0][SIGFIG-1:0]  slot_reg [LANES];

  logic                    accept;
  logic                    at_top;
  logic                    issue_go;

  assign in_ready = rst & (state_reg == FILL);
  assign accept   = in_valid & in_ready;
  assign at_top   = (fill_reg == FILLW'(LANES - 1));
  assign issue_go = (state_reg == ISSUE) & ~halt;
  assign err      = err_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= FILL;
      fill_reg  <= '0;
      mask_reg  <= '0;
      tag_reg   <= '0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      mask_reg[fill_reg] <= 1'b1;
      fill_reg           <= fill_reg + 1'b1;
      if (fill_reg == '0)
        tag_reg <= in_tag;
      else if (in_tag != tag_reg)
        err_reg <= 1'b1;
      if (at_top || in_last) begin
        state_reg <= ISSUE;
        last_reg  <= in_last;
      end
    end else if (issue_go) begin
      state_reg <= FILL;
      fill_reg  <= '0;
      mask_reg  <= '0;
    end
  end

  // Slots that were not filled are zeroed on the output so stale samples
  // from an earlier group never reach the lanes.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (!rst)
          slot_reg[gi] <= '0;
        else if (accept && (fill_reg == FILLW'(gi)))
          slot_reg[gi] <= in_sample;
      end
      assign issue_valid[gi]  = (state_reg == ISSUE) & mask_reg[gi];
      assign issue_sample[gi] = issue_valid[gi] ? slot_reg[gi] : '0;
    end
  endgenerate

  // Shadow pipeline: an empty record is inserted on every advancing cycle
  // without an issue so the output stage stays cycle-aligned with ret_hit.
  grp_tag_t shadow_in;
  grp_tag_t shadow_out;

  always_comb begin
    shadow_in = '0;
    if (issue_go) begin
      shadow_in.mask = mask_reg;
      shadow_in.tag  = tag_reg;
      shadow_in.last = last_reg;
    end
  end

  smpl_tag_shift #(
    .DEPTH (PIPE_DEPTH)
  ) u_tag_shift (
    .clk (clk),
    .rst (rst),
    .en  (~halt),
    .d   (shadow_in),
    .q   (shadow_out)
  );

  logic [POPW-1:0] hits;
  logic [SUMW-1:0] sum_wide;
  logic [CNTW-1:0] sum_sat;
  logic [CNTW-1:0] acc_reg;

  always_comb begin
    hits = '0;
    for (int i = 0; i < LANES; i++)
      hits = hits + POPW'(ret_hit[i] & shadow_out.mask[i]);
  end

  assign sum_wide = {1'b0, acc_reg} + SUMW'(hits);
  assign sum_sat  = sum_wide[CNTW] ? '1 : sum_wide[CNTW-1:0];

  // Nothing at the shadow output is consumed while halted, so a done record
  // cannot repeat across a stall and held ret_hit values are never counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg    <= '0;
      done_valid <= 1'b0;
      done_tag   <= '0;
      done_hits  <= '0;
    end else begin
      done_valid <= 1'b0;
      if (!halt) begin
        if (shadow_out.last) begin
          done_valid <= 1'b1;
          done_tag   <= shadow_out.tag;
          done_hits  <= sum_sat;
          acc_reg    <= '0;
        end else begin
          acc_reg <= sum_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_smpl_lane_sched.sv
// tb_smpl_lane_sched
// Directed bench for smpl_lane_sched: feeds hand-built triangles, logs
// every issued group and every done pulse with its cycle number, and
// compares against hand-computed expectations.
module tb_smpl_lane_sched;

  localparam int SIGFIG     = 24;
  localparam int LANES      = 3;
  localparam int PIPE_DEPTH = 3;
  localparam int TAGW       = 4;
  localparam int CNTW       = 16;

  typedef logic [LANES-1:0][1:0][SIGFIG-1:0] grp_t;

  logic                        clk;
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  logic [1:0][SIGFIG-1:0]      in_sample;
  logic [TAGW-1:0]             in_tag;
  logic                        in_last;
  logic                        halt;
  logic [LANES-1:0]            issue_valid;
  grp_t                        issue_sample;
  logic [LANES-1:0]            ret_hit;
  logic                        done_valid;
  logic [TAGW-1:0]             done_tag;
  logic [CNTW-1:0]             done_hits;
  logic                        err;

  smpl_lane_sched #(
    .SIGFIG     (SIGFIG),
    .LANES      (LANES),
    .PIPE_DEPTH (PIPE_DEPTH),
    .TAGW       (TAGW),
    .CNTW       (CNTW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sample    (in_sample),
    .in_tag       (in_tag),
    .in_last      (in_last),
    .halt         (halt),
    .issue_valid  (issue_valid),
    .issue_sample (issue_sample),
    .ret_hit      (ret_hit),
    .done_valid   (done_valid),
    .done_tag     (done_tag),
    .done_hits    (done_hits),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int               vec_cnt  = 0;
  int               miss_cnt = 0;
  int               last_acc_cyc = 0;

  int               iss_cyc [$];
  logic [LANES-1:0] iss_mask [$];
  grp_t             iss_data [$];
  int               dn_cyc [$];
  logic [TAGW-1:0]  dn_tag [$];
  logic [CNTW-1:0]  dn_hits [$];

  // Cycle label = value of cyc during that cycle (sampled mid-cycle).
  always @(negedge clk) begin
    if (done_valid) begin
      dn_cyc.push_back(cyc);
      dn_tag.push_back(done_tag);
      dn_hits.push_back(done_hits);
    end
    if ((|issue_valid) && !halt) begin
      iss_cyc.push_back(cyc);
      iss_mask.push_back(issue_valid);
      iss_data.push_back(issue_sample);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clear_logs();
    iss_cyc.delete(); iss_mask.delete(); iss_data.delete();
    dn_cyc.delete(); dn_tag.delete(); dn_hits.delete();
  endtask

  // Pad logs after their sizes were checked so indexed reads stay in range.
  task automatic pad_logs();
    while (iss_cyc.size() < 4) begin
      iss_cyc.push_back(-1000); iss_mask.push_back('0); iss_data.push_back('0);
    end
    while (dn_cyc.size() < 4) begin
      dn_cyc.push_back(-1000); dn_tag.push_back('1); dn_hits.push_back('1);
    end
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic send(input logic [TAGW-1:0] tag, input logic last, input int k);
    bit got;
    in_valid     = 1'b1;
    in_tag       = tag;
    in_last      = last;
    in_sample[0] = SIGFIG'(32'h100000 + k);
    in_sample[1] = SIGFIG'(32'h200000 + k);
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        last_acc_cyc = cyc;
      end
    end
    if (!got) check_eq("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input string tag, input int n);
    for (int k = 0; k < 60 && dn_cyc.size() < n; k++) begin
      @(posedge clk); #1;
    end
    // extra cycles so a duplicated or stale pulse would also be logged
    repeat (PIPE_DEPTH + 4) begin @(posedge clk); #1; end
    check_eq(tag, 64'(dn_cyc.size()), 64'(n));
  endtask

  grp_t g;

  initial begin
    rst = 1'b0; in_valid = 1'b1; in_sample = '0; in_tag = '0; in_last = 1'b0;
    halt = 1'b0; ret_hit = '0;
    repeat (3) begin @(posedge clk); #1; end

    // ---- reset state (in_valid held high to show in_ready is forced low)
    check_eq("rst_in_ready",    64'(in_ready),     64'd0);
    check_eq("rst_issue_valid", 64'(issue_valid),  64'd0);
    check_eq("rst_issue_samp",  64'(issue_sample), 64'd0);
    check_eq("rst_done_valid",  64'(done_valid),   64'd0);
    check_eq("rst_done_tag",    64'(done_tag),     64'd0);
    check_eq("rst_done_hits",   64'(done_hits),    64'd0);
    check_eq("rst_err",         64'(err),          64'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("fill_in_ready", 64'(in_ready), 64'd1);

    // ---- T1: tag 5, six samples, all hits
    clear_logs();
    ret_hit = 3'b111;
    for (int k = 0; k < 6; k++) send(4'd5, k == 5, k);
    idle(1);
    wait_done("t1_ndone", 1);
    check_eq("t1_ngroups", 64'(iss_cyc.size()), 64'd2);
    pad_logs();
    check_eq("t1_mask0", 64'(iss_mask[0]), 64'b111);
    check_eq("t1_mask1", 64'(iss_mask[1]), 64'b111);
    g = iss_data[0];
    check_eq("t1_g0_l2_x", 64'(g[2][0]), 64'h100002);
    g = iss_data[1];
    check_eq("t1_g1_l0_x", 64'(g[0][0]), 64'h100003);
    check_eq("t1_g1_l1_y", 64'(g[1][1]), 64'h200004);
    // three accepts plus one issue cycle per full group
    check_eq("t1_issue_gap", 64'(iss_cyc[1] - iss_cyc[0]), 64'd4);
    check_eq("t1_done_tag",  64'(dn_tag[0]),  64'd5);
    check_eq("t1_done_hits", 64'(dn_hits[0]), 64'd6);
    // ret_hit is taken PIPE_DEPTH cycles after issue; done registers on that
    // cycle's closing edge, so it is visible one cycle later
    check_eq("t1_latency", 64'(dn_cyc[0] - iss_cyc[1]), 64'(PIPE_DEPTH + 1));
    check_eq("t1_hold_valid", 64'(done_valid), 64'd0);
    check_eq("t1_hold_tag",   64'(done_tag),   64'd5);
    check_eq("t1_hold_hits",  64'(done_hits),  64'd6);

    // ---- T2: tag 2, four samples, ret_hit 101 on both groups
    clear_logs();
    ret_hit = 3'b101;
    for (int k = 10; k < 14; k++) send(4'd2, k == 13, k);
    idle(1);
    wait_done("t2_ndone", 1);
    check_eq("t2_ngroups", 64'(iss_cyc.size()), 64'd2);
    pad_logs();
    check_eq("t2_mask0", 64'(iss_mask[0]), 64'b111);
    check_eq("t2_mask1", 64'(iss_mask[1]), 64'b001);
    g = iss_data[1];
    check_eq("t2_g1_l0_x",   64'(g[0][0]), 64'h10000D);
    check_eq("t2_g1_l1_zero", 64'(g[1][0]), 64'd0);
    check_eq("t2_g1_l2_zero", 64'(g[2][1]), 64'd0);
    check_eq("t2_done_tag",  64'(dn_tag[0]),  64'd2);
    check_eq("t2_done_hits", 64'(dn_hits[0]), 64'd3);

    // ---- T3: tag 6, one group, halt 4 cycles in ISSUE and 2 in flight
    clear_logs();
    ret_hit = 3'b111;
    send(4'd6, 1'b0, 20);
    send(4'd6, 1'b0, 21);
    send(4'd6, 1'b1, 22);
    in_valid = 1'b0;
    in_last  = 1'b0;
    halt = 1'b1;
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      check_eq("t3_halt_valid", 64'(issue_valid), 64'b111);
      check_eq("t3_halt_samp",  64'(issue_sample[2][0]), 64'h100016);
    end
    check_eq("t3_halt_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    halt = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    halt = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    halt = 1'b0;
    wait_done("t3_ndone", 1);
    check_eq("t3_ngroups", 64'(iss_cyc.size()), 64'd1);
    pad_logs();
    check_eq("t3_issue_cyc", 64'(iss_cyc[0] - last_acc_cyc), 64'd5);
    // unhalted: accept+1 issue, +PIPE_DEPTH+1 done; plus 4+2 halt cycles
    check_eq("t3_done_cyc", 64'(dn_cyc[0] - last_acc_cyc), 64'(PIPE_DEPTH + 8));
    check_eq("t3_done_tag",  64'(dn_tag[0]),  64'd6);
    check_eq("t3_done_hits", 64'(dn_hits[0]), 64'd3);

    // ---- T4: tag 1 (single sample) then tag 3 (three samples)
    clear_logs();
    ret_hit = 3'b111;
    send(4'd1, 1'b1, 30);
    send(4'd3, 1'b0, 31);
    send(4'd3, 1'b0, 32);
    send(4'd3, 1'b1, 33);
    idle(1);
    wait_done("t4_ndone", 2);
    check_eq("t4_ngroups", 64'(iss_cyc.size()), 64'd2);
    pad_logs();
    check_eq("t4_mask0", 64'(iss_mask[0]), 64'b001);
    check_eq("t4_mask1", 64'(iss_mask[1]), 64'b111);
    check_eq("t4_tag0",  64'(dn_tag[0]),  64'd1);
    check_eq("t4_hits0", 64'(dn_hits[0]), 64'd1);
    check_eq("t4_tag1",  64'(dn_tag[1]),  64'd3);
    check_eq("t4_hits1", 64'(dn_hits[1]), 64'd3);
    check_eq("t4_done_gap", 64'(dn_cyc[1] - dn_cyc[0]), 64'd4);

    // ---- T5: tag switch 4 -> 7 inside a group
    clear_logs();
    send(4'd4, 1'b0, 40);
    check_eq("t5_err_before", 64'(err), 64'd0);
    send(4'd7, 1'b0, 41);
    check_eq("t5_err_set", 64'(err), 64'd1);
    idle(5);
    check_eq("t5_err_sticky", 64'(err), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_err_cleared", 64'(err), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // ---- T6: reset with a group counted and two samples pending
    clear_logs();
    ret_hit = 3'b111;
    for (int k = 50; k < 55; k++) send(4'd8, 1'b0, k);
    idle(3);
    check_eq("t6_no_done_pre", 64'(dn_cyc.size()), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send(4'd9, 1'b0, 60);
    send(4'd9, 1'b0, 61);
    send(4'd9, 1'b1, 62);
    idle(1);
    wait_done("t6_ndone", 1);
    pad_logs();
    check_eq("t6_done_tag",  64'(dn_tag[0]),  64'd9);
    check_eq("t6_done_hits", 64'(dn_hits[0]), 64'd3);
    check_eq("t6_err", 64'(err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
